// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the fetch-stage sequencer:
//   - fs_state_e     : 3-bit FSM state encodings (BOOT, RUN, STALL, FLUSH, HALT)
//   - fs_out_t       : registered control outputs driven in each state
//   - state_outputs  : maps a state to its enbl/dec/halted values
//   - max_int        : elaboration-time helper used to size the sequencing counter
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  localparam int DEF_PC_W = 7;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } fs_state_e;

  typedef struct packed {
    logic enbl;
    logic dec;
    logic halted;
  } fs_out_t;

  function automatic fs_out_t state_outputs(input fs_state_e s);
    fs_out_t o;
    o = '0;
    case (s)
      ST_BOOT: begin
        o.enbl = 1'b1;
        o.dec  = 1'b0;
      end
      ST_RUN: begin
        o.enbl = 1'b1;
        o.dec  = 1'b1;
      end
      ST_STALL: begin
        o.enbl = 1'b0;
        o.dec  = 1'b1;
      end
      ST_FLUSH: begin
        o.enbl = 1'b1;
        o.dec  = 1'b0;
      end
      ST_HALT: begin
        o.enbl   = 1'b0;
        o.dec    = 1'b1;
        o.halted = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_sat_counter
//   Saturating up-counter with asynchronous clear. Increments by one on each
//   clock where i_en is high and holds at all-ones instead of wrapping.
// Ports
//   i_clk  : clock
//   i_rst  : asynchronous active-high clear
//   i_en   : count enable
//   o_cnt  : current count [W-1:0]
// -----------------------------------------------------------------------------
module fetch_sequencer_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Control unit for the fetch stage. Drives fetch enbl (0 holds PC) and
//   dec (1 = sequential PC + real instruction, 0 = redirect PC + NOP).
//   Sequences instruction-memory priming after reset, load-use stalls,
//   taken-branch redirect with wrong-path flush, and halt/resume. Counts
//   lost fetch cycles (STALL and FLUSH) in a saturating perf counter.
//
// Ports
//   i_clk            : clock, all state on posedge
//   i_rst            : asynchronous active-high reset
//   i_branch_taken   : pulse, redirect fetch to i_branch_target
//   i_branch_target  : target PC [PC_W-1:0], valid with i_branch_taken
//   i_stall_req      : level, hold PC and instruction
//   i_halt_req       : pulse, freeze fetch until i_resume_req
//   i_resume_req     : pulse, leave HALT
//   o_fetch_enbl     : fetch enable
//   o_fetch_dec      : fetch sequential/redirect select
//   o_pc_target      : redirect PC [PC_W-1:0]
//   o_halted         : high while in HALT
//   o_bubble_cnt     : saturating lost-cycle count [CNT_W-1:0]
//
// State table
//   state | meaning
//   BOOT  | memory prime after reset: enbl=1 dec=0, only branches accepted
//   RUN   | normal sequential fetch: enbl=1 dec=1
//   STALL | hazard hold: enbl=0 dec=1, left on first cycle stall_req=0
//   FLUSH | wrong-path squash after taken branch: enbl=1 dec=0
//   HALT  | frozen: enbl=0 dec=1 halted=1, only resume_req accepted
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int BOOT_CYCLES  = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_branch_taken,
  input  logic [PC_W-1:0]  i_branch_target,
  input  logic             i_stall_req,
  input  logic             i_halt_req,
  input  logic             i_resume_req,
  output logic             o_fetch_enbl,
  output logic             o_fetch_dec,
  output logic [PC_W-1:0]  o_pc_target,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_bubble_cnt
);

  localparam int SEQ_W = $clog2(max_int(FLUSH_CYCLES, BOOT_CYCLES)) + 1;
  localparam logic [SEQ_W-1:0] FLUSH_LOAD = SEQ_W'(FLUSH_CYCLES - 1);
  localparam logic [SEQ_W-1:0] BOOT_LAST  = SEQ_W'(BOOT_CYCLES);

  fs_state_e        r_state;
  logic [SEQ_W-1:0] r_seq_cnt;
  logic [PC_W-1:0]  r_pc_target;
  logic             r_enbl;
  logic             r_dec;
  logic             r_halted;

  fs_state_e        w_state_nxt;
  logic [SEQ_W-1:0] w_seq_nxt;
  logic [PC_W-1:0]  w_tgt_nxt;
  fs_out_t          w_out_nxt;
  logic             w_bubble_en;

  // Reset leaves the outputs at 0/0 with the counter at 0. BOOT counts up so
  // that the visible enbl=1/dec=0 priming window lasts exactly BOOT_CYCLES
  // cycles after reset release; FLUSH reuses the same counter as a
  // down-counter terminating at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_seq_nxt   = r_seq_cnt;
    w_tgt_nxt   = r_pc_target;
    case (r_state)
      ST_BOOT: begin
        if (i_branch_taken) begin
          w_state_nxt = ST_FLUSH;
          w_seq_nxt   = FLUSH_LOAD;
          w_tgt_nxt   = i_branch_target;
        end else if (r_seq_cnt == BOOT_LAST) begin
          w_state_nxt = ST_RUN;
          w_seq_nxt   = '0;
        end else begin
          w_seq_nxt = r_seq_cnt + 1'b1;
        end
      end
      ST_RUN, ST_STALL: begin
        if (i_branch_taken) begin
          w_state_nxt = ST_FLUSH;
          w_seq_nxt   = FLUSH_LOAD;
          w_tgt_nxt   = i_branch_target;
        end else if (i_halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (i_stall_req) begin
          w_state_nxt = ST_STALL;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // A branch here re-latches the target and opens a fresh window.
        // stall_req only matters on the exit cycle.
        if (i_branch_taken) begin
          w_seq_nxt = FLUSH_LOAD;
          w_tgt_nxt = i_branch_target;
        end else if (i_halt_req) begin
          w_state_nxt = ST_HALT;
        end else if (r_seq_cnt == '0) begin
          w_state_nxt = i_stall_req ? ST_STALL : ST_RUN;
        end else begin
          w_seq_nxt = r_seq_cnt - 1'b1;
        end
      end
      ST_HALT: begin
        if (i_resume_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_seq_nxt   = '0;
      end
    endcase
  end

  assign w_out_nxt = state_outputs(w_state_nxt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_BOOT;
      r_seq_cnt   <= '0;
      r_pc_target <= '0;
      r_enbl      <= 1'b0;
      r_dec       <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_seq_cnt   <= w_seq_nxt;
      r_pc_target <= w_tgt_nxt;
      r_enbl      <= w_out_nxt.enbl;
      r_dec       <= w_out_nxt.dec;
      r_halted    <= w_out_nxt.halted;
    end
  end

  // Lost cycles are those spent in STALL or FLUSH; BOOT and HALT are excluded.
  assign w_bubble_en = (r_state == ST_STALL) || (r_state == ST_FLUSH);

  fetch_sequencer_sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_bubble_en),
    .o_cnt (o_bubble_cnt)
  );

  assign o_fetch_enbl = r_enbl;
  assign o_fetch_dec  = r_dec;
  assign o_pc_target  = r_pc_target;
  assign o_halted     = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam int PC_W = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            br  = 1'b0;
  logic [PC_W-1:0] tgt = '0;
  logic            stall = 1'b0;
  logic            halt  = 1'b0;
  logic            resume = 1'b0;

  logic            enbl, dec, halted;
  logic [PC_W-1:0] pc;
  logic [15:0]     bub;

  logic            enbl2, dec2, halted2;
  logic [PC_W-1:0] pc2;
  logic [1:0]      bub2;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_branch_taken  (br),
    .i_branch_target (tgt),
    .i_stall_req     (stall),
    .i_halt_req      (halt),
    .i_resume_req    (resume),
    .o_fetch_enbl    (enbl),
    .o_fetch_dec     (dec),
    .o_pc_target     (pc),
    .o_halted        (halted),
    .o_bubble_cnt    (bub)
  );

  // Narrow counter copy sharing the same stimulus, for saturation.
  fetch_sequencer #(.CNT_W(2)) dut_sat (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_branch_taken  (br),
    .i_branch_target (tgt),
    .i_stall_req     (stall),
    .i_halt_req      (halt),
    .i_resume_req    (resume),
    .o_fetch_enbl    (enbl2),
    .o_fetch_dec     (dec2),
    .o_pc_target     (pc2),
    .o_halted        (halted2),
    .o_bubble_cnt    (bub2)
  );

  typedef struct {
    string           name;
    logic            enbl;
    logic            dec;
    logic [PC_W-1:0] pc;
    logic            halted;
    int              bub;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t       m_e;
  logic [1:0] m_bub2;

  // Monitor: the DUT presents a new output set every cycle; compare at negedge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_e    = q.pop_front();
      m_bub2 = (m_e.bub > 3) ? 2'd3 : 2'(m_e.bub);
      n_checks++;
      if (enbl !== m_e.enbl || dec !== m_e.dec || pc !== m_e.pc ||
          halted !== m_e.halted || bub !== 16'(m_e.bub) || bub2 !== m_bub2) begin
        n_errors++;
        $display("FAIL %s: got enbl=%b dec=%b pc=%h halted=%b bub=%0d bub2=%0d, want enbl=%b dec=%b pc=%h halted=%b bub=%0d bub2=%0d",
                 m_e.name, enbl, dec, pc, halted, bub, bub2,
                 m_e.enbl, m_e.dec, m_e.pc, m_e.halted, m_e.bub, m_bub2);
      end
    end
  end

  task automatic push_exp(input string nm, input logic e_en, input logic e_dec,
                          input logic [PC_W-1:0] e_pc, input logic e_h, input int e_bub);
    exp_t e;
    e.name   = nm;
    e.enbl   = e_en;
    e.dec    = e_dec;
    e.pc     = e_pc;
    e.halted = e_h;
    e.bub    = e_bub;
    q.push_back(e);
  endtask

  // Drive one cycle of requests (just after negedge), expect outputs after the edge.
  task automatic step(input string nm, input logic b, input logic [PC_W-1:0] t,
                      input logic s, input logic h, input logic r,
                      input logic e_en, input logic e_dec, input logic [PC_W-1:0] e_pc,
                      input logic e_h, input int e_bub);
    br     = b;
    tgt    = t;
    stall  = s;
    halt   = h;
    resume = r;
    @(posedge clk);
    push_exp(nm, e_en, e_dec, e_pc, e_h, e_bub);
    @(negedge clk);
  endtask

  // Assert reset between edges; outputs must clear immediately.
  task automatic do_reset(input string nm);
    #2;
    rst    = 1'b1;
    br     = 1'b0;
    tgt    = '0;
    stall  = 1'b0;
    halt   = 1'b0;
    resume = 1'b0;
    push_exp(nm, 1'b0, 1'b0, '0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset("reset");
    // name          br tgt    st ha re   en dec pc     h  bub
    step("boot",      0, 7'h00, 0, 0, 0,  1, 0, 7'h00, 0, 0);
    step("run0",      0, 7'h00, 0, 0, 0,  1, 1, 7'h00, 0, 0);
    step("run1",      0, 7'h00, 0, 0, 0,  1, 1, 7'h00, 0, 0);
    // taken branch, two flush cycles
    step("br25",      1, 7'h25, 0, 0, 0,  1, 0, 7'h25, 0, 0);
    step("fl25_2",    0, 7'h00, 0, 0, 0,  1, 0, 7'h25, 0, 1);
    step("fl25_run",  0, 7'h00, 0, 0, 0,  1, 1, 7'h25, 0, 2);
    step("run2",      0, 7'h00, 0, 0, 0,  1, 1, 7'h25, 0, 2);
    // three-cycle stall
    step("stall1",    0, 7'h00, 1, 0, 0,  0, 1, 7'h25, 0, 2);
    step("stall2",    0, 7'h00, 1, 0, 0,  0, 1, 7'h25, 0, 3);
    step("stall3",    0, 7'h00, 1, 0, 0,  0, 1, 7'h25, 0, 4);
    step("stall_end", 0, 7'h00, 0, 0, 0,  1, 1, 7'h25, 0, 5);
    // branch beats stall; stall still high at flush exit
    step("brst",      1, 7'h11, 1, 0, 0,  1, 0, 7'h11, 0, 5);
    step("brst_fl2",  0, 7'h00, 1, 0, 0,  1, 0, 7'h11, 0, 6);
    step("brst_st1",  0, 7'h00, 1, 0, 0,  0, 1, 7'h11, 0, 7);
    step("brst_st2",  0, 7'h00, 1, 0, 0,  0, 1, 7'h11, 0, 8);
    step("brst_run",  0, 7'h00, 0, 0, 0,  1, 1, 7'h11, 0, 9);
    // back-to-back branches extend the flush
    step("br10",      1, 7'h10, 0, 0, 0,  1, 0, 7'h10, 0, 9);
    step("br30",      1, 7'h30, 0, 0, 0,  1, 0, 7'h30, 0, 10);
    step("fl30_3",    0, 7'h00, 0, 0, 0,  1, 0, 7'h30, 0, 11);
    step("fl30_run",  0, 7'h00, 0, 0, 0,  1, 1, 7'h30, 0, 12);
    // branch beats halt and stall
    step("brhalt",    1, 7'h22, 1, 1, 0,  1, 0, 7'h22, 0, 12);
    step("brhalt_fl", 0, 7'h00, 0, 0, 0,  1, 0, 7'h22, 0, 13);
    step("brhalt_rn", 0, 7'h00, 0, 0, 0,  1, 1, 7'h22, 0, 14);
    // halt wins over resume; requests ignored in HALT
    step("halt_res",  0, 7'h00, 0, 1, 1,  0, 1, 7'h22, 1, 14);
    step("halt_br",   1, 7'h55, 0, 0, 0,  0, 1, 7'h22, 1, 14);
    step("halt_st",   0, 7'h00, 1, 1, 0,  0, 1, 7'h22, 1, 14);
    step("resume",    0, 7'h00, 0, 0, 1,  1, 1, 7'h22, 0, 14);
    step("halt2",     0, 7'h00, 0, 1, 0,  0, 1, 7'h22, 1, 14);
    step("halt2_hold",0, 7'h00, 0, 0, 0,  0, 1, 7'h22, 1, 14);
    do_reset("rst_halt");
    // branch accepted during BOOT, halt/stall ignored there
    step("boot2",     0, 7'h00, 0, 0, 0,  1, 0, 7'h00, 0, 0);
    step("boot_br",   1, 7'h7f, 1, 1, 0,  1, 0, 7'h7f, 0, 0);
    step("boot_fl2",  0, 7'h00, 0, 0, 0,  1, 0, 7'h7f, 0, 1);
    step("boot_run",  0, 7'h00, 0, 0, 0,  1, 1, 7'h7f, 0, 2);
    step("br01",      1, 7'h01, 0, 0, 0,  1, 0, 7'h01, 0, 2);
    do_reset("rst_flush");
    step("boot3",     0, 7'h00, 0, 0, 0,  1, 0, 7'h00, 0, 0);
    step("boot_halt", 0, 7'h00, 0, 1, 0,  1, 1, 7'h00, 0, 0);
    // five stalls: narrow counter sticks at 3
    step("sat1",      0, 7'h00, 1, 0, 0,  0, 1, 7'h00, 0, 0);
    step("sat2",      0, 7'h00, 1, 0, 0,  0, 1, 7'h00, 0, 1);
    step("sat3",      0, 7'h00, 1, 0, 0,  0, 1, 7'h00, 0, 2);
    step("sat4",      0, 7'h00, 1, 0, 0,  0, 1, 7'h00, 0, 3);
    step("sat5",      0, 7'h00, 1, 0, 0,  0, 1, 7'h00, 0, 4);
    step("sat_run",   0, 7'h00, 0, 0, 0,  1, 1, 7'h00, 0, 5);
    step("st_again",  0, 7'h00, 1, 0, 0,  0, 1, 7'h00, 0, 5);
    do_reset("rst_stall");
    step("boot4",     0, 7'h00, 0, 0, 0,  1, 0, 7'h00, 0, 0);
    step("run_end",   0, 7'h00, 0, 0, 0,  1, 1, 7'h00, 0, 0);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
